// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: tracking entry and forwarding-select encoding.
package hazard_ctrl_pkg;

    // Entries carry a fixed-width destination so the struct is parameter-free; RA_W must not exceed this.
    localparam int RA_W_MAX = 8;

    localparam int SEL_RF = 0;

    typedef struct packed {
        logic                valid;
        logic                wr;
        logic [RA_W_MAX-1:0] rd;
        logic                load;
    } entry_t;

endpackage

// File: rtl/hazard_match.sv
// Compares one source register against every tracked stage; reports the youngest matching stage.
module hazard_match
    import hazard_ctrl_pkg::*;
#(
    parameter int DEPTH = 3,
    parameter int RA_W  = 5
) (
    input  entry_t                       entries [DEPTH],
    input  logic [RA_W-1:0]              src,
    input  logic                         used,
    output logic                         hit,
    output logic [$clog2(DEPTH+1)-1:0]   idx,
    output logic                         is_load
);

    localparam int SEL_W = $clog2(DEPTH+1);

    // Scan oldest to youngest so the youngest match is the one left standing.
    always_comb begin
        hit     = 1'b0;
        idx     = SEL_W'(SEL_RF);
        is_load = 1'b0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (used && (src != '0) && entries[k].valid && entries[k].wr &&
                (entries[k].rd == RA_W_MAX'(src))) begin
                hit     = 1'b1;
                idx     = SEL_W'(k + 1);
                is_load = entries[k].load;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks DEPTH post-decode stages and produces stall, flush and forwarding selects.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int RA_W   = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       dec_valid,
    input  logic [RA_W-1:0]            dec_rs,
    input  logic [RA_W-1:0]            dec_rt,
    input  logic                       dec_rs_used,
    input  logic                       dec_rt_used,
    input  logic                       dec_wr,
    input  logic [RA_W-1:0]            dec_rd,
    input  logic                       dec_load,
    input  logic                       ex_branch_taken,
    input  logic                       dec_jump,
    output logic                       stall,
    output logic                       flush_if,
    output logic                       bubble_ex,
    output logic [$clog2(DEPTH+1)-1:0] fwd_rs_sel,
    output logic [$clog2(DEPTH+1)-1:0] fwd_rt_sel,
    output logic [CNT_W-1:0]           stall_cnt,
    output logic [CNT_W-1:0]           flush_cnt
);

    localparam int SEL_W = $clog2(DEPTH+1);

    entry_t           pipe [DEPTH];
    entry_t           dec_entry;
    logic             rs_hit, rt_hit, rs_load, rt_load;
    logic [SEL_W-1:0] rs_idx, rt_idx;
    logic             hazard;
    logic             accept;

    hazard_match #(.DEPTH(DEPTH), .RA_W(RA_W)) u_match_rs (
        .entries (pipe),
        .src     (dec_rs),
        .used    (dec_rs_used),
        .hit     (rs_hit),
        .idx     (rs_idx),
        .is_load (rs_load)
    );

    hazard_match #(.DEPTH(DEPTH), .RA_W(RA_W)) u_match_rt (
        .entries (pipe),
        .src     (dec_rt),
        .used    (dec_rt_used),
        .hit     (rt_hit),
        .idx     (rt_idx),
        .is_load (rt_load)
    );

    // With forwarding only a load still in stage 1 cannot be bypassed; without it any match waits for retire.
    always_comb begin
        if (FWD_EN != 0) begin
            hazard = (rs_hit && rs_load && (rs_idx == SEL_W'(1))) ||
                     (rt_hit && rt_load && (rt_idx == SEL_W'(1)));
        end else begin
            hazard = rs_hit || rt_hit;
        end
    end

    assign stall      = hazard && dec_valid && !ex_branch_taken;
    assign bubble_ex  = stall || ex_branch_taken;
    assign flush_if   = ex_branch_taken || (dec_jump && dec_valid && !stall);
    assign fwd_rs_sel = (FWD_EN != 0) ? rs_idx : SEL_W'(SEL_RF);
    assign fwd_rt_sel = (FWD_EN != 0) ? rt_idx : SEL_W'(SEL_RF);
    assign accept     = dec_valid && !stall && !ex_branch_taken;

    always_comb begin
        dec_entry       = '0;
        dec_entry.valid = 1'b1;
        dec_entry.wr    = dec_wr;
        dec_entry.rd    = RA_W_MAX'(dec_rd);
        dec_entry.load  = dec_load;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                pipe[k] <= '0;
            end
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            pipe[0] <= accept ? dec_entry : '0;
            for (int k = 1; k < DEPTH; k++) begin
                pipe[k] <= pipe[k-1];
            end
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_if && (flush_cnt != '1)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: default, no-forwarding and 4-bit-counter instances.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_valid, dec_rs_used, dec_rt_used, dec_wr, dec_load;
    logic [4:0] dec_rs, dec_rt, dec_rd;
    logic       ex_branch_taken, dec_jump;

    logic        s_stall, s_flush, s_bubble;
    logic [1:0]  s_frs, s_frt;
    logic [15:0] s_sc, s_fc;
    logic        n_stall, n_flush, n_bubble;
    logic [1:0]  n_frs, n_frt;
    logic [15:0] n_sc, n_fc;
    logic        c_stall, c_flush, c_bubble;
    logic [1:0]  c_frs, c_frt;
    logic [3:0]  c_sc, c_fc;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used), .dec_wr(dec_wr), .dec_rd(dec_rd),
        .dec_load(dec_load), .ex_branch_taken(ex_branch_taken), .dec_jump(dec_jump),
        .stall(s_stall), .flush_if(s_flush), .bubble_ex(s_bubble),
        .fwd_rs_sel(s_frs), .fwd_rt_sel(s_frt), .stall_cnt(s_sc), .flush_cnt(s_fc)
    );

    hazard_ctrl #(.FWD_EN(0)) dut_nf (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used), .dec_wr(dec_wr), .dec_rd(dec_rd),
        .dec_load(dec_load), .ex_branch_taken(ex_branch_taken), .dec_jump(dec_jump),
        .stall(n_stall), .flush_if(n_flush), .bubble_ex(n_bubble),
        .fwd_rs_sel(n_frs), .fwd_rt_sel(n_frt), .stall_cnt(n_sc), .flush_cnt(n_fc)
    );

    hazard_ctrl #(.CNT_W(4)) dut_c4 (
        .clk(clk), .rst(rst), .dec_valid(dec_valid), .dec_rs(dec_rs), .dec_rt(dec_rt),
        .dec_rs_used(dec_rs_used), .dec_rt_used(dec_rt_used), .dec_wr(dec_wr), .dec_rd(dec_rd),
        .dec_load(dec_load), .ex_branch_taken(ex_branch_taken), .dec_jump(dec_jump),
        .stall(c_stall), .flush_if(c_flush), .bubble_ex(c_bubble),
        .fwd_rs_sel(c_frs), .fwd_rt_sel(c_frt), .stall_cnt(c_sc), .flush_cnt(c_fc)
    );

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic       rs_used;
        logic [4:0] rt;
        logic       rt_used;
        logic       wr;
        logic [4:0] rd;
        logic       load;
        logic       br;
        logic       jump;
        logic [6:0] e_out;   // {stall, flush_if, bubble_ex, fwd_rs_sel, fwd_rt_sel}
        logic [15:0] e_sc;
        logic [15:0] e_fc;
    } vec_t;

    vec_t tbl [20];
    vec_t sb [$];

    function automatic vec_t mk(input logic v, input int rs, input logic rsu, input int rt,
                                input logic rtu, input logic wr, input int rd, input logic ld,
                                input logic br, input logic jmp, input logic e_st, input logic e_fl,
                                input logic e_bb, input int e_frs, input int e_frt,
                                input int e_sc, input int e_fc);
        vec_t r;
        r.valid = v;   r.rs = 5'(rs); r.rs_used = rsu; r.rt = 5'(rt); r.rt_used = rtu;
        r.wr = wr;     r.rd = 5'(rd); r.load = ld;     r.br = br;     r.jump = jmp;
        r.e_out = {e_st, e_fl, e_bb, 2'(e_frs), 2'(e_frt)};
        r.e_sc = 16'(e_sc);
        r.e_fc = 16'(e_fc);
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input int rs, input logic rsu, input int rt, input logic rtu,
                         input logic wr, input int rd, input logic ld, input logic br, input logic jmp);
        dec_valid = v;   dec_rs = 5'(rs); dec_rs_used = rsu; dec_rt = 5'(rt); dec_rt_used = rtu;
        dec_wr = wr;     dec_rd = 5'(rd); dec_load = ld;     ex_branch_taken = br; dec_jump = jmp;
    endtask

    task automatic reset_pulse();
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        vec_t e;
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // stimulus, expected {stall,flush,bubble,frs,frt}, expected counters (before the edge)
        tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0,  0, 0, 0, 0, 0,  0, 0);
        tbl[2]  = mk(1, 3, 1, 0, 0, 1, 4, 0, 0, 0,  0, 0, 0, 1, 0,  0, 0);
        tbl[3]  = mk(1, 3, 1, 4, 1, 1, 3, 0, 0, 0,  0, 0, 0, 2, 1,  0, 0);
        tbl[4]  = mk(1, 3, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0,  0, 0);
        tbl[5]  = mk(1, 4, 1, 0, 1, 1, 0, 0, 0, 0,  0, 0, 0, 3, 0,  0, 0);
        tbl[6]  = mk(1, 0, 1, 3, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 3,  0, 0);
        tbl[7]  = mk(1, 0, 0, 0, 0, 1, 5, 1, 0, 0,  0, 0, 0, 0, 0,  0, 0);
        tbl[8]  = mk(1, 0, 0, 5, 1, 1, 6, 0, 0, 0,  1, 0, 1, 0, 1,  0, 0);
        tbl[9]  = mk(1, 0, 0, 5, 1, 1, 6, 0, 0, 0,  0, 0, 0, 0, 2,  1, 0);
        tbl[10] = mk(1, 0, 0, 0, 0, 1, 7, 1, 0, 0,  0, 0, 0, 0, 0,  1, 0);
        tbl[11] = mk(0, 7, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0,  1, 0);
        tbl[12] = mk(1, 0, 0, 0, 0, 1, 8, 1, 0, 0,  0, 0, 0, 0, 0,  1, 0);
        tbl[13] = mk(1, 8, 1, 0, 0, 0, 0, 0, 1, 1,  0, 1, 1, 1, 0,  1, 0);
        tbl[14] = mk(1, 8, 1, 0, 0, 0, 0, 0, 0, 1,  0, 1, 0, 2, 0,  1, 1);
        tbl[15] = mk(1, 0, 0, 0, 0, 1, 9, 1, 0, 0,  0, 0, 0, 0, 0,  1, 2);
        tbl[16] = mk(1, 0, 0, 9, 1, 0, 0, 0, 0, 1,  1, 0, 1, 0, 1,  1, 2);
        tbl[17] = mk(0, 0, 0, 9, 1, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2,  2, 2);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0,  0, 1, 1, 0, 0,  2, 2);
        tbl[19] = mk(1, 9, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0,  2, 3);

        // Outputs while reset is held
        @(negedge clk);
        #2;
        check("rst_out", {25'd0, s_stall, s_flush, s_bubble, s_frs, s_frt}, 32'd0);
        check("rst_cnt", {s_sc, s_fc}, 32'd0);
        check("rst_nf_c4", {n_stall, n_bubble, c_stall, c_bubble, n_sc, c_sc}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].valid, int'(tbl[i].rs), tbl[i].rs_used, int'(tbl[i].rt), tbl[i].rt_used,
                  tbl[i].wr, int'(tbl[i].rd), tbl[i].load, tbl[i].br, tbl[i].jump);
            sb.push_back(tbl[i]);
            #2;
            e = sb.pop_front();
            check($sformatf("row%0d_out", i), {25'd0, s_stall, s_flush, s_bubble, s_frs, s_frt},
                  {25'd0, e.e_out});
            check($sformatf("row%0d_cnt", i), {s_sc, s_fc}, {e.e_sc, e.e_fc});
        end

        // No forwarding: add r7 then a dependent instruction waits until r7 retires
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_pulse();
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 7, 0, 0, 0);
        #2;
        check("nf_add", {30'd0, n_stall, n_bubble}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(1, 7, 1, 0, 0, 1, 1, 0, 0, 0);
            #2;
            check($sformatf("nf_stall%0d", i), {29'd0, n_stall, n_frs},
                  {29'd0, (i < 3) ? 1'b1 : 1'b0, 2'd0});
        end
        check("nf_stall_cnt", 32'(n_sc), 32'd3);

        // Saturating 4-bit counter over 20 load-use stalls, then reset mid-stall
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset_pulse();
        @(negedge clk);
        drive(1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            drive(1, 5, 1, 0, 0, 1, 5, 1, 0, 0);
            #2;
            check($sformatf("c4_stall%0d", i), 32'(c_stall), (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        @(negedge clk);
        #2;
        check("c4_sat", {27'd0, c_stall, c_sc}, {27'd0, 1'b1, 4'd15});
        rst = 1'b1;
        #1;
        check("c4_rst_now", {27'd0, c_stall, c_sc}, 32'd0);
        rst = 1'b0;
        #1;
        check("c4_post_rst", {30'd0, c_stall, c_bubble}, 32'd0);
        @(negedge clk);
        #2;
        check("c4_reaccept", {27'd0, c_stall, c_sc}, {27'd0, 1'b1, 4'd0});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
